// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//   Fetch sequencer sitting between pc_counter and the instruction memory /
//   decode stage. It computes the next PC that pc_counter registers, issues the
//   imem request for the current PC, and marks which returned instructions are
//   architecturally valid. It handles boot, sequential fetch, taken redirects
//   (including ones that arrive while a fetch is still outstanding), downstream
//   stalls and a fetch-timeout fault that stays set until explicitly cleared.
//
// Ports
//   clk                in   rising-edge clock
//   rst                in   asynchronous reset, active-high
//   address_i          in   current PC (pc_counter address_o)
//   PC_next_o          out  next PC (pc_counter PC_next)
//   imem_req_o         out  fetch request at address_i
//   imem_ready_i       in   imem data valid for the current request
//   instr_valid_o      out  fetched instruction is architecturally valid
//   stall_i            in   downstream cannot accept an instruction
//   redirect_i         in   branch/jump taken this cycle
//   redirect_target_i  in   redirect destination
//   fault_o            out  fetch timeout fault (sticky)
//   fault_clr_i        in   clears fault and restarts at RESET_VECTOR
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int                       ADDRESS_WIDTH  = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR   = '0,
  parameter int                       INSTR_BYTES    = 4,
  parameter int                       TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] address_i,
  output logic [ADDRESS_WIDTH-1:0] PC_next_o,
  output logic                     imem_req_o,
  input  logic                     imem_ready_i,
  output logic                     instr_valid_o,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
  output logic                     fault_o,
  input  logic                     fault_clr_i
);

  localparam int                       CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]            TO_VAL = CW'(TIMEOUT_CYCLES);
  localparam logic [ADDRESS_WIDTH-1:0] INC    = ADDRESS_WIDTH'(INSTR_BYTES);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                   r_state,       w_state_nxt;
  logic                     r_pend_valid,  w_pend_valid_nxt;
  logic [ADDRESS_WIDTH-1:0] r_pend_target, w_pend_target_nxt;
  logic [CW-1:0]            r_wait_cnt,    w_wait_cnt_nxt;
  logic [CW-1:0]            w_cnt_inc;

  assign w_cnt_inc = r_wait_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= BOOT;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
      r_wait_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_target <= w_pend_target_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_target_nxt = r_pend_target;
    w_wait_cnt_nxt    = r_wait_cnt;
    PC_next_o         = address_i;
    imem_req_o        = 1'b0;
    instr_valid_o     = 1'b0;
    fault_o           = 1'b0;

    case (r_state)
      BOOT: begin
        PC_next_o   = RESET_VECTOR;
        w_state_nxt = FETCH;
      end

      FETCH: begin
        if (stall_i) begin
          // Hold the PC and the timeout count; a redirect seen now must not be lost.
          if (redirect_i) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_target_nxt = redirect_target_i;
          end
        end else begin
          imem_req_o = 1'b1;
          if (imem_ready_i) begin
            w_wait_cnt_nxt = '0;
            // The completing instruction is on the wrong path if any redirect
            // is live, so it is dropped and the PC steers to the new target.
            if (redirect_i) begin
              PC_next_o        = redirect_target_i;
              w_pend_valid_nxt = 1'b0;
            end else if (r_pend_valid) begin
              PC_next_o        = r_pend_target;
              w_pend_valid_nxt = 1'b0;
            end else begin
              PC_next_o     = address_i + INC;
              instr_valid_o = 1'b1;
            end
          end else begin
            w_wait_cnt_nxt = w_cnt_inc;
            if (redirect_i) begin
              w_pend_valid_nxt  = 1'b1;
              w_pend_target_nxt = redirect_target_i;
            end
            if (w_cnt_inc == TO_VAL) begin
              w_state_nxt = FAULT;
            end
          end
        end
      end

      FAULT: begin
        fault_o = 1'b1;
        if (fault_clr_i) begin
          w_state_nxt      = BOOT;
          w_pend_valid_nxt = 1'b0;
          w_wait_cnt_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//   Bench for pc_fetch_ctrl. A behavioural pc_counter (PC register loaded from
//   PC_next_o) closes the loop on address_i; an override lets a sequence park
//   the PC at an arbitrary address. Each cycle's expected outputs are queued
//   when the inputs are driven and popped when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address_i;
  logic [31:0] PC_next_o;
  logic        imem_req_o;
  logic        imem_ready_i;
  logic        instr_valid_o;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        fault_o;
  logic        fault_clr_i;

  logic [31:0] pc_q;
  logic        ovr;
  logic [31:0] ovr_addr;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    logic        vld;
    logic        flt;
  } exp_t;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        redir;
    logic [31:0] tgt;
    logic        clr;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];

  pc_fetch_ctrl #(
    .ADDRESS_WIDTH (32),
    .RESET_VECTOR  (32'h0),
    .INSTR_BYTES   (4),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .address_i        (address_i),
    .PC_next_o        (PC_next_o),
    .imem_req_o       (imem_req_o),
    .imem_ready_i     (imem_ready_i),
    .instr_valid_o    (instr_valid_o),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_target_i(redirect_target_i),
    .fault_o          (fault_o),
    .fault_clr_i      (fault_clr_i)
  );

  always #5 clk = ~clk;

  // pc_counter model
  always @(posedge clk or posedge rst) begin
    if (rst) pc_q <= 32'h0;
    else     pc_q <= PC_next_o;
  end

  assign address_i = ovr ? ovr_addr : pc_q;

  function automatic exp_t E(input logic [31:0] pc, input logic req,
                             input logic vld, input logic flt);
    exp_t e;
    e.pc = pc; e.req = req; e.vld = vld; e.flt = flt;
    return e;
  endfunction

  task automatic add(input logic s, input logic r, input logic rd,
                     input logic [31:0] t, input logic c, input exp_t e);
    vec_t v;
    v.stall = s; v.ready = r; v.redir = rd; v.tgt = t; v.clr = c; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name);
    exp_t e;
    exp_t got;
    got = E(PC_next_o, imem_req_o, instr_valid_o, fault_o);
    tests++;
    if (sb_q.size() == 0) begin
      failed++;
      $display("FAIL %s: scoreboard empty, got pc=%h req=%b vld=%b flt=%b",
               name, got.pc, got.req, got.vld, got.flt);
      return;
    end
    e = sb_q.pop_front();
    if (got !== e) begin
      failed++;
      $display("FAIL %s: got pc=%h req=%b vld=%b flt=%b, expected pc=%h req=%b vld=%b flt=%b",
               name, got.pc, got.req, got.vld, got.flt, e.pc, e.req, e.vld, e.flt);
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input logic s, input logic r, input logic rd,
                      input logic [31:0] t, input logic c, input exp_t e,
                      input string name);
    stall_i = s; imem_ready_i = r; redirect_i = rd;
    redirect_target_i = t; fault_clr_i = c;
    sb_q.push_back(e);
    #1;
    check(name);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ovr = 1'b0; ovr_addr = 32'h0;
    stall_i = 0; imem_ready_i = 0; redirect_i = 0;
    redirect_target_i = 0; fault_clr_i = 0;

    // stall, ready, redirect, target, clr, expected {pc, req, vld, flt}
    // boot then sequential fetch with ready tied high
    add(0, 1, 0, 32'h0,   0, E(32'h0,   0, 0, 0));
    add(0, 1, 0, 32'h0,   0, E(32'h4,   1, 1, 0));
    add(0, 1, 0, 32'h0,   0, E(32'h8,   1, 1, 0));
    add(0, 1, 0, 32'h0,   0, E(32'hC,   1, 1, 0));
    // wait states at 0xC
    add(0, 0, 0, 32'h0,   0, E(32'hC,   1, 0, 0));
    add(0, 0, 0, 32'h0,   0, E(32'hC,   1, 0, 0));
    add(0, 1, 0, 32'h0,   0, E(32'h10,  1, 1, 0));
    // redirect during wait becomes pending, taken on completion
    add(0, 0, 1, 32'h100, 0, E(32'h10,  1, 0, 0));
    add(0, 1, 0, 32'h0,   0, E(32'h100, 1, 0, 0));
    add(0, 1, 0, 32'h0,   0, E(32'h104, 1, 1, 0));
    // redirect coincident with completion
    add(0, 1, 1, 32'h200, 0, E(32'h200, 1, 0, 0));
    // later pending redirect (during stall) overwrites earlier one
    add(0, 0, 1, 32'h300, 0, E(32'h200, 1, 0, 0));
    add(1, 0, 1, 32'h400, 0, E(32'h200, 0, 0, 0));
    add(0, 1, 0, 32'h0,   0, E(32'h400, 1, 0, 0));
    // live redirect beats pending one, and pending is cleared
    add(0, 0, 1, 32'h500, 0, E(32'h400, 1, 0, 0));
    add(0, 1, 1, 32'h600, 0, E(32'h600, 1, 0, 0));
    add(0, 1, 0, 32'h0,   0, E(32'h604, 1, 1, 0));
    // stall holds the PC, drops req, ignores ready
    add(1, 0, 0, 32'h0,   0, E(32'h604, 0, 0, 0));
    add(1, 0, 0, 32'h0,   0, E(32'h604, 0, 0, 0));
    add(1, 0, 0, 32'h0,   0, E(32'h604, 0, 0, 0));
    add(1, 1, 0, 32'h0,   0, E(32'h604, 0, 0, 0));
    add(0, 1, 0, 32'h0,   0, E(32'h608, 1, 1, 0));

    @(negedge clk);
    step(0, 1, 1, 32'h55, 1, E(32'h0, 0, 0, 0), "reset_state");
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].stall, tbl[i].ready, tbl[i].redir, tbl[i].tgt, tbl[i].clr,
           tbl[i].e, $sformatf("tbl[%0d]", i));
    end

    // Timeout: 14 unanswered requests, a stall that must not reset the count,
    // then the 15th unanswered request.
    for (int i = 0; i < 14; i++)
      step(0, 0, 0, 32'h0, 0, E(32'h608, 1, 0, 0), $sformatf("wait%0d", i));
    step(1, 0, 0, 32'h0, 0, E(32'h608, 0, 0, 0), "wait_stall0");
    step(1, 0, 0, 32'h0, 0, E(32'h608, 0, 0, 0), "wait_stall1");
    step(0, 0, 0, 32'h0, 0, E(32'h608, 1, 0, 0), "wait14");
    step(0, 1, 1, 32'h700, 0, E(32'h608, 0, 0, 1), "fault_enter");
    step(1, 1, 0, 32'h0,   0, E(32'h608, 0, 0, 1), "fault_sticky");
    step(0, 0, 0, 32'h0,   1, E(32'h608, 0, 0, 1), "fault_clr");
    step(0, 1, 1, 32'h900, 0, E(32'h0,   0, 0, 0), "boot_after_clr");
    step(0, 1, 0, 32'h0,   0, E(32'h4,   1, 1, 0), "fetch_after_clr");
    step(0, 1, 0, 32'h0,   1, E(32'h8,   1, 1, 0), "clr_ignored");

    // Address wrap at the top of the space
    ovr = 1'b1; ovr_addr = 32'hFFFF_FFFC;
    step(0, 1, 0, 32'h0, 0, E(32'h0, 1, 1, 0), "wrap");
    ovr = 1'b0;
    step(0, 0, 0,  32'h0,  0, E(32'h0, 1, 0, 0), "pre_rst_wait0");
    step(0, 0, 1,  32'h40, 0, E(32'h0, 1, 0, 0), "pre_rst_wait1");

    // Reset in the middle of a wait with a redirect pending
    stall_i = 0; imem_ready_i = 1; redirect_i = 0; fault_clr_i = 0;
    rst = 1'b1;
    sb_q.push_back(E(32'h0, 0, 0, 0));
    #1;
    check("rst_mid_wait");
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 32'h0, 0, E(32'h0, 0, 0, 0), "boot_after_rst");
    step(0, 1, 0, 32'h0, 0, E(32'h4, 1, 1, 0), "pend_lost");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
